// File: rtl/rv_pipe_ctrl.sv
// rtl/rv_pipe_ctrl.sv - RV pipeline control: hazard stall, redirect flush, memory-busy freeze (optional RV_FORWARD_EN)
module rv_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [4:0]  ID_OP0_ADDR,
  input  logic [4:0]  ID_OP1_ADDR,
  input  logic        ID_REG_RD_EN,
  input  logic [4:0]  EX_RD_ADDR,
  input  logic        EX_REG_WR_EN,
  input  logic        EX_MEM_RD_EN,
  input  logic [4:0]  MEM_RD_ADDR,
  input  logic        MEM_REG_WR_EN,
  input  logic        EX_JUMP_EN,
  input  logic [31:0] EX_JUMP_ADDR,
  input  logic        MEM_BUSY,
  output logic        PC_STALL,
  output logic        IF2ID_HOLD,
  output logic        EX_HOLD,
  output logic        WASH_EN,
  output logic        IF_FLUSH,
  output logic        PC_LOAD,
  output logic [31:0] PC_LOAD_ADDR,
  output logic [1:0]  PIPE_STATE
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  // Counter value loaded on a redirect; the redirect cycle itself is the first washed cycle.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic       GO_FLUSH   = (FLUSH_CYCLES > 1);

  state_t      state, state_n;
  state_t      ret_state, ret_state_n;
  logic [2:0]  cnt, cnt_n;
  logic [2:0]  ret_cnt, ret_cnt_n;
  logic        pend_vld, pend_vld_n;
  logic [31:0] pend_addr, pend_addr_n;

  state_t      eff_state;
  logic [2:0]  eff_cnt;
  logic        redirect;
  logic [31:0] redirect_addr;

  logic        ex_match;
  logic        mem_match;
  logic        hazard;

  assign ex_match  = (EX_RD_ADDR != 5'd0) && EX_REG_WR_EN &&
                     ((EX_RD_ADDR == ID_OP0_ADDR) || (EX_RD_ADDR == ID_OP1_ADDR));
  assign mem_match = (MEM_RD_ADDR != 5'd0) && MEM_REG_WR_EN &&
                     ((MEM_RD_ADDR == ID_OP0_ADDR) || (MEM_RD_ADDR == ID_OP1_ADDR));

`ifdef RV_FORWARD_EN
  // Forwarding covers ALU results; only a load still in EX cannot be bypassed in time.
  logic unused_mem_match;
  assign unused_mem_match = mem_match;
  assign hazard = ID_REG_RD_EN && ex_match && EX_MEM_RD_EN;
`else
  // No bypass network: any pending write to a source register must drain first.
  logic unused_ex_load;
  assign unused_ex_load = EX_MEM_RD_EN;
  assign hazard = ID_REG_RD_EN && (ex_match || mem_match);
`endif

  // While frozen, the state/counter to act upon are the ones saved on entry.
  always_comb begin
    eff_state = state;
    eff_cnt   = cnt;
    if (state == MEM_WAIT) begin
      eff_state = ret_state;
      eff_cnt   = ret_cnt;
    end
  end

  // Next-state and output decode; priority is reset > busy > redirect > hazard.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    ret_state_n   = ret_state;
    ret_cnt_n     = ret_cnt;
    pend_vld_n    = pend_vld;
    pend_addr_n   = pend_addr;
    redirect      = 1'b0;
    redirect_addr = 32'd0;
    PC_STALL      = 1'b0;
    IF2ID_HOLD    = 1'b0;
    EX_HOLD       = 1'b0;
    WASH_EN       = 1'b0;
    IF_FLUSH      = 1'b0;
    PC_LOAD       = 1'b0;
    PC_LOAD_ADDR  = 32'd0;

    if (!nRST) begin
      state_n     = RUN;
      cnt_n       = 3'd0;
      ret_state_n = RUN;
      ret_cnt_n   = 3'd0;
      pend_vld_n  = 1'b0;
      pend_addr_n = 32'd0;
    end else if (state == ILLEGAL) begin
      state_n    = RUN;
      cnt_n      = 3'd0;
      pend_vld_n = 1'b0;
    end else if (MEM_BUSY) begin
      PC_STALL   = 1'b1;
      IF2ID_HOLD = 1'b1;
      EX_HOLD    = 1'b1;
      state_n    = MEM_WAIT;
      if (state != MEM_WAIT) begin
        ret_state_n = state;
        ret_cnt_n   = cnt;
      end
      if (EX_JUMP_EN) begin
        pend_vld_n  = 1'b1;
        pend_addr_n = EX_JUMP_ADDR;
      end
    end else begin
      pend_vld_n  = 1'b0;
      pend_addr_n = 32'd0;
      // A live EX redirect is newer than one parked during the freeze.
      if (EX_JUMP_EN) begin
        redirect      = 1'b1;
        redirect_addr = EX_JUMP_ADDR;
      end else if ((state == MEM_WAIT) && pend_vld) begin
        redirect      = 1'b1;
        redirect_addr = pend_addr;
      end

      if (redirect) begin
        PC_LOAD      = 1'b1;
        PC_LOAD_ADDR = redirect_addr;
        WASH_EN      = 1'b1;
        IF_FLUSH     = 1'b1;
        cnt_n        = FLUSH_INIT;
        state_n      = GO_FLUSH ? FLUSH : RUN;
      end else if (eff_state == FLUSH) begin
        WASH_EN  = 1'b1;
        IF_FLUSH = 1'b1;
        if (eff_cnt <= 3'd1) begin
          state_n = RUN;
          cnt_n   = 3'd0;
        end else begin
          state_n = FLUSH;
          cnt_n   = eff_cnt - 3'd1;
        end
      end else begin
        state_n = RUN;
        cnt_n   = 3'd0;
        if (hazard) begin
          PC_STALL   = 1'b1;
          IF2ID_HOLD = 1'b1;
          WASH_EN    = 1'b1;
        end
      end
    end
  end

  // State, counter, saved context and pending redirect registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      cnt       <= 3'd0;
      ret_state <= RUN;
      ret_cnt   <= 3'd0;
      pend_vld  <= 1'b0;
      pend_addr <= 32'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ret_state <= ret_state_n;
      ret_cnt   <= ret_cnt_n;
      pend_vld  <= pend_vld_n;
      pend_addr <= pend_addr_n;
    end
  end

  assign PIPE_STATE = nRST ? state : 2'd0;

endmodule
